// File: rtl/uart_dft_top.sv
// uart_dft_top: 8-N-1 UART command receiver that drives a status LED.
// The LED and the received-byte register double as a 9-bit scan chain:
//   scan_in -> led -> rx_data[7] -> ... -> rx_data[0] -> scan_out
// Optional feature macro: UART_TX_ECHO_EN (echo every valid byte on tx).
// Handshake: rx_valid is a single-cycle strobe with no ready. rx_data holds
// the byte from that cycle until the next valid byte or scan shift. A strobe
// that arrives while the transmitter is busy is dropped.
module uart_dft_top #(
    parameter int          CLKS_PER_BIT = 8,
    parameter logic [7:0]  CMD_LED_ON   = 8'hA1,
    parameter logic [7:0]  CMD_LED_OFF  = 8'hA0
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    output logic led,
    input  logic scan_enable,
    input  logic scan_in,
    output logic scan_out
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_state_next;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_bit_done;

    assign rx_bit_done = (rx_cnt == BIT_LAST);

    // Two-flop synchronizer on the serial input; frozen while scanning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else if (!scan_enable) begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register; holds its state while scanning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rx_state <= RX_IDLE;
        else if (!scan_enable)
            rx_state <= rx_state_next;
    end

    // Receiver next-state: half-bit start check, then 8 mid-bit samples and a stop sample.
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_state_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_done && rx_idx == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_bit_done) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // Receiver bit timing and LSB-first deserializer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else if (!scan_enable) begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                end
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_bit_done) begin
                        rx_cnt   <= '0;
                        rx_idx   <= rx_idx + 1'b1;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= rx_bit_done ? '0 : rx_cnt + 1'b1;
                default: rx_cnt <= '0;
            endcase
        end
    end

    // Scan chain in scan mode; otherwise byte capture, valid strobe and LED decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led      <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (scan_enable) begin
            led      <= scan_in;
            rx_data  <= {led, rx_data[7:1]};
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state == RX_STOP && rx_bit_done && rx_sync) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
            if (rx_valid) begin
                if (rx_data == CMD_LED_ON)
                    led <= 1'b1;
                else if (rx_data == CMD_LED_OFF)
                    led <= 1'b0;
            end
        end
    end

    assign scan_out = rx_data[0];

`ifdef UART_TX_ECHO_EN
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          tx_bit_done;
    logic          tx_load;

    assign tx_bit_done = (tx_cnt == BIT_LAST);
    // The last stop-bit cycle may hand straight over to a new frame.
    assign tx_load = rx_valid && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_done));

    // Transmitter state register; holds its state while scanning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tx_state <= TX_IDLE;
        else if (!scan_enable)
            tx_state <= tx_state_next;
    end

    // Transmitter next-state: start, 8 data bits LSB first, stop.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (rx_valid) tx_state_next = TX_START;
            TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_idx == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_state_next = rx_valid ? TX_START : TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // Transmitter serializer; tx is a flop so it simply holds while scanning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else if (!scan_enable) begin
            if (tx_load) begin
                tx       <= 1'b0;
                tx_shift <= rx_data;
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        tx     <= 1'b1;
                        tx_cnt <= '0;
                    end
                    TX_START: begin
                        if (tx_bit_done) begin
                            tx     <= tx_shift[0];
                            tx_cnt <= '0;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_bit_done) begin
                            tx_cnt <= '0;
                            tx_idx <= tx_idx + 1'b1;
                            if (tx_idx == 3'd7) begin
                                tx <= 1'b1;
                            end else begin
                                tx       <= tx_shift[1];
                                tx_shift <= {1'b0, tx_shift[7:1]};
                            end
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_STOP: tx_cnt <= tx_bit_done ? '0 : tx_cnt + 1'b1;
                    default: tx_cnt <= '0;
                endcase
            end
        end
    end
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_dft_top.sv
// tb_uart_dft_top: directed stimulus for uart_dft_top with a cycle-level
// behavioural model (frame-level latencies, chain contents, echo timeline)
// compared against led, scan_out and tx on every falling edge, plus literal
// expectations taken from hand-worked examples.
module tb_uart_dft_top;

    localparam int CPB      = 8;
    localparam int FRAME    = 10 * CPB;
    // Stop-bit sample edge, counted from the edge that launched the start bit:
    // 2 synchronizer + 1 edge detect + half bit + 9 full bits.
    localparam int DONE_LAT = 2 + 1 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic scan_enable = 1'b0;
    logic scan_in = 1'b0;
    logic tx, led, scan_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state
    logic       m_led = 1'b0;
    logic [7:0] m_rx = 8'h00;
    int         tx_start = -1000;
    logic [7:0] tx_byte = 8'h00;
    int         v_cyc = -1;
    logic [7:0] v_byte = 8'h00;
    int         pend_q[$];
    logic [7:0] exp_q[$];

    uart_dft_top #(
        .CLKS_PER_BIT(CPB),
        .CMD_LED_ON  (8'hA1),
        .CMD_LED_OFF (8'hA0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .tx         (tx),
        .led        (led),
        .scan_enable(scan_enable),
        .scan_in    (scan_in),
        .scan_out   (scan_out)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_tx(input int n);
        int idx;
        if (n < tx_start || n >= tx_start + FRAME) return 1'b1;
        idx = (n - tx_start) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return tx_byte[idx-1];
    endfunction

    // Model: advances once per rising edge, or clears on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_led    = 1'b0;
            m_rx     = 8'h00;
            tx_start = -1000;
            v_cyc    = -1;
            pend_q.delete();
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            if (scan_enable) begin
                {m_led, m_rx} = {scan_in, m_led, m_rx[7:1]};
            end else begin
                if (cyc == v_cyc) begin
                    if (v_byte == 8'hA1) m_led = 1'b1;
                    else if (v_byte == 8'hA0) m_led = 1'b0;
`ifdef UART_TX_ECHO_EN
                    if (cyc >= tx_start + FRAME) begin
                        tx_start = cyc;
                        tx_byte  = v_byte;
                    end
`endif
                end
                if (pend_q.size() > 0 && cyc == pend_q[0]) begin
                    m_rx   = exp_q[0];
                    v_byte = exp_q[0];
                    v_cyc  = cyc + 1;
                    void'(pend_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        check("led", led, m_led);
        check("scan_out", scan_out, m_rx[0]);
        check("tx", tx, exp_tx(cyc));
    end

    // Driver tasks (entered and left 1 time unit after a rising edge)
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (stop) begin
            pend_q.push_back(cyc + DONE_LAT);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            rx = bits[i];
            idle(CPB);
        end
    endtask

    task automatic shift_chain(input logic [8:0] pattern);
        scan_enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            scan_in = pattern[i];
            idle(1);
        end
        scan_enable = 1'b0;
        scan_in = 1'b0;
    endtask

    // Stimulus
    initial begin
        logic [9:0] echo_lit;
        logic [8:0] scan_lit;
        int t0;
        echo_lit = 10'b1001111000;
        scan_lit = 9'b110100001;

        idle(5);
        check("reset_led", led, 1'b0);
        check("reset_tx", tx, 1'b1);
        check("reset_scan_out", scan_out, 1'b0);
        rst = 1'b1;
        idle(10);

        send_frame(8'hA1, 1'b1);
        idle(2);
        check("a1_led", led, 1'b1);
        check("a1_scan_out", scan_out, 1'b1);
        idle(16);

        send_frame(8'hA0, 1'b1);
        idle(2);
        check("a0_led", led, 1'b0);
        idle(16);
        send_frame(8'h55, 1'b1);
        idle(2);
        check("x55_led", led, 1'b0);
        check("x55_scan_out", scan_out, 1'b1);
        idle(100);

        send_frame(8'h3C, 1'b1);
        t0 = cyc;
`ifdef UART_TX_ECHO_EN
        for (int b = 0; b < 10; b++) begin
            idle((b == 0) ? CPB / 2 : CPB);
            check("echo_3c_bit", tx, echo_lit[b]);
        end
`else
        idle(CPB * 5);
        check("no_echo_tx", tx, echo_lit[9]);
`endif
        idle(100);

        send_frame(8'hA0, 1'b1);
        idle(16);
        send_frame(8'hA1, 1'b0);
        idle(4);
        check("frame_err_led", led, 1'b0);
        check("frame_err_scan_out", scan_out, 1'b0);
        idle(20);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(30);
        send_frame(8'hA1, 1'b1);
        idle(2);
        check("after_err_led", led, 1'b1);
        idle(100);

        scan_enable = 1'b1;
        scan_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("scan_seq", scan_out, scan_lit[i]);
            idle(1);
        end
        scan_enable = 1'b0;
        idle(1);
        check("scan_led_cleared", led, 1'b0);
        shift_chain(9'b1_0101_1010 >> 0 == 9'h0 ? 9'h0 : {1'b1, 8'h5A});
        idle(5);
        check("scan_load_led", led, 1'b1);
        check("scan_load_out", scan_out, 1'b0);
        send_frame(8'hA0, 1'b1);
        idle(2);
        check("post_scan_a0_led", led, 1'b0);
        idle(100);

        send_frame(8'hA1, 1'b1);
        send_partial(8'hA0, 3);
        rst = 1'b0;
        #1;
        check("midframe_rst_led", led, 1'b0);
        check("midframe_rst_tx", tx, 1'b1);
        check("midframe_rst_scan", scan_out, 1'b0);
        rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(10);
        send_frame(8'hA1, 1'b1);
        idle(2);
        check("after_rst_a1_led", led, 1'b1);
        idle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
